// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and its decode partner:
// state encodings, PC-select codes and RISC-V base opcodes.
package exec_sequencer_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned PC_SEL_W = 2;
  localparam int unsigned WAIT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_sel_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/exec_sequencer_wait_timer.sv
// Consecutive-wait-cycle counter; expire_c flags the TIMEOUT-th
// unacknowledged cycle so the sequencer can fault on that same edge.
module wait_timer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic cnt_en,
  output logic expire_c
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  assign expire_c = cnt_en && (cnt_q == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_en && !expire_c) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, optional memory access,
// write-back, with a bus-wait timeout that parks the core in a sticky fault.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [XLEN-1:0]     instr_in,
  output logic [XLEN-1:0]     ir,
  input  logic                branch,
  input  logic                jump,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                write_enable,
  input  logic                take_branch,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                pc_we,
  output logic [PC_SEL_W-1:0] pc_sel,
  output logic                rf_we,
  output logic [STATE_W-1:0]  state,
  output logic                fault,
  output logic [CNT_W-1:0]    retired
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [XLEN-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic in_fetch, in_mem, in_wb;
  logic ack_c, timer_clear, timer_en, timer_expire_c;

  assign in_fetch = (state_q == S_FETCH);
  assign in_mem   = (state_q == S_MEM);
  assign in_wb    = (state_q == S_WB);

  // Only the ack matching the current wait state counts; others are ignored.
  assign ack_c       = (in_fetch && imem_ack) || (in_mem && dmem_ack);
  assign timer_clear = !(in_fetch || in_mem) || ack_c;
  assign timer_en    = (in_fetch || in_mem) && !ack_c;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .cnt_en   (timer_en),
    .expire_c (timer_expire_c)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end else if (timer_expire_c) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (mem_read && mem_write)      state_d = S_FAULT;
        else if (mem_read || mem_write) state_d = S_MEM;
        else                            state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)            state_d = S_WB;
        else if (timer_expire_c) state_d = S_FAULT;
      end
      S_WB: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Strobes decode straight off the state register so reset clears them at once.
  assign imem_req = in_fetch;
  assign dmem_req = in_mem;
  assign dmem_we  = in_mem && mem_write;
  assign pc_we    = in_wb;
  assign rf_we    = in_wb && write_enable && !mem_write;
  assign pc_sel   = !in_wb                 ? PC_PLUS4  :
                    jump                   ? PC_JUMP   :
                    (branch && take_branch) ? PC_BRANCH : PC_PLUS4;

  assign state   = state_q;
  assign fault   = (state_q == S_FAULT);
  assign ir      = ir_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: per-instruction expectations are queued
// when an instruction is issued and checked when the DUT reaches write-back.
module tb_exec_sequencer;
  import exec_sequencer_pkg::*;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h0000006F;

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0, take_branch = 1'b0;
  logic branch = 1'b0, jump = 1'b0, mem_read = 1'b0, mem_write = 1'b0, write_enable = 1'b0;
  logic [31:0] instr_in = '0;
  logic imem_req, dmem_req, dmem_we, pc_we, rf_we, fault;
  logic [31:0] ir;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic [CNT_W-1:0] retired;

  typedef struct {
    logic [1:0]       pc_sel;
    logic             rf_we;
    logic [CNT_W-1:0] retired;
    logic [31:0]      instr;
    int               cycles;
    int               dwe_cycles;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_retired = '0;
  bit stray_ack = 1'b0;

  exec_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr_in(instr_in), .ir(ir),
    .branch(branch), .jump(jump), .mem_read(mem_read), .mem_write(mem_write),
    .write_enable(write_enable), .take_branch(take_branch),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .state(state), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  // Acts as the decode block for the fetched word.
  task automatic set_decode(input logic [31:0] instr);
    logic [6:0] op;
    op           = opcode_of(instr);
    branch       = (op == OP_BRANCH);
    jump         = (op == OP_JAL) || (op == OP_JALR);
    mem_read     = (op == OP_LOAD);
    mem_write    = (op == OP_STORE);
    write_enable = !((op == OP_BRANCH) || (op == OP_STORE));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    set_decode(32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0 || ir !== 32'h0 || retired !== '0 || fault !== 1'b0 ||
        imem_req !== 1'b0 || dmem_req !== 1'b0 || pc_we !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: state=%0d ir=%h retired=%0d fault=%b imem_req=%b dmem_req=%b, want all 0",
               state, ir, retired, fault, imem_req, dmem_req);
    end
    rst_n = 1'b1;
    exp_retired = '0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold: state=%0d want 0", state);
    end
  endtask

  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL start_fetch: state=%0d want 1", state);
    end
  endtask

  // Issue one instruction from FETCH; iw/dw = wait cycles before imem/dmem ack.
  task automatic run_instr(input logic [31:0] instr, input logic tk, input int iw,
                           input int dw, input bit drop_run, input string name);
    exp_t e, got;
    int cyc, fw, mw, dwe_cnt, dec_cnt;
    bit done, is_mem;
    set_decode(instr);
    take_branch = tk;
    is_mem = mem_read || mem_write;
    e.pc_sel     = jump ? 2'b10 : (branch && tk) ? 2'b01 : 2'b00;
    e.rf_we      = write_enable && !mem_write;
    e.retired    = CNT_W'(exp_retired + 1'b1);
    e.instr      = instr;
    e.cycles     = 3 + iw + (is_mem ? 1 + dw : 0);
    e.dwe_cycles = mem_write ? dw + 1 : 0;
    exp_retired  = e.retired;
    sb.push_back(e);
    cyc = 0; fw = 0; mw = 0; dwe_cnt = 0; dec_cnt = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      case (state)
        3'd1: begin
          imem_ack = (fw == iw);
          instr_in = imem_ack ? instr : 32'hDEAD_BEEF;
          dmem_ack = stray_ack;
          fw++;
        end
        3'd2: begin
          imem_ack = 1'b0;
          dmem_ack = stray_ack;
          dec_cnt++;
          if (drop_run) run = 1'b0;
        end
        3'd3: begin
          imem_ack = stray_ack;
          dmem_ack = (mw == dw);
          if (dmem_we === 1'b1) dwe_cnt++;
          mw++;
        end
        3'd4: begin
          imem_ack = 1'b0;
          dmem_ack = 1'b0;
          got = sb.pop_front();
          checks++;
          if (pc_sel !== got.pc_sel || rf_we !== got.rf_we || pc_we !== 1'b1) begin
            errors++;
            $display("FAIL %s_wb: pc_sel=%b rf_we=%b pc_we=%b want pc_sel=%b rf_we=%b pc_we=1",
                     name, pc_sel, rf_we, pc_we, got.pc_sel, got.rf_we);
          end
          checks++;
          if (cyc + 1 != got.cycles || dwe_cnt != got.dwe_cycles || dec_cnt != 1) begin
            errors++;
            $display("FAIL %s_timing: cycles=%0d dmem_we_cycles=%0d decode_cycles=%0d want %0d %0d 1",
                     name, cyc + 1, dwe_cnt, dec_cnt, got.cycles, got.dwe_cycles);
          end
          checks++;
          if (ir !== got.instr) begin
            errors++;
            $display("FAIL %s_ir: ir=%h want %h", name, ir, got.instr);
          end
          done = 1'b1;
        end
        default: ;
      endcase
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_no_wb: write-back not reached within %0d cycles, state=%0d", name, cyc, state);
    end else if (retired !== e.retired || fault !== 1'b0 || state !== (run ? 3'd1 : 3'd0)) begin
      errors++;
      $display("FAIL %s_after_wb: retired=%0d fault=%b state=%0d want retired=%0d fault=0 state=%0d",
               name, retired, fault, state, e.retired, run ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add();
    start_run();
    run_instr(I_ADD, 1'b0, 0, 0, 1'b0, "add");
  endtask

  task automatic test_store();
    run_instr(I_SW, 1'b0, 0, 2, 1'b0, "sw");
  endtask

  task automatic test_branch_jump();
    run_instr(I_BEQ, 1'b1, 0, 0, 1'b0, "beq_taken");
    run_instr(I_BEQ, 1'b0, 1, 0, 1'b0, "beq_not_taken");
    run_instr(I_JAL, 1'b0, 0, 0, 1'b0, "jal");
  endtask

  task automatic test_back_to_back();
    stray_ack = 1'b1;
    run_instr(I_LW, 1'b0, 2, 3, 1'b0, "lw_stray_ack");
    run_instr(I_ADD, 1'b0, 1, 0, 1'b0, "add_stray_ack");
    stray_ack = 1'b0;
    run_instr(I_SW, 1'b0, 0, 0, 1'b0, "sw_fast");
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    start_run();
    imem_ack = 1'b0;
    n = 0;
    while (state === 3'd1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != TIMEOUT || fault !== 1'b1 || state !== 3'd5 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_timeout: fetch_cycles=%0d fault=%b state=%0d imem_req=%b want %0d 1 5 0",
               n, fault, state, imem_req, TIMEOUT);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fault !== 1'b1 || state !== 3'd5 || pc_we !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky: fault=%b state=%0d pc_we=%b dmem_req=%b want 1 5 0 0",
               fault, state, pc_we, dmem_req);
    end
  endtask

  task automatic test_ack_on_timeout();
    do_reset();
    start_run();
    run_instr(I_ADD, 1'b0, TIMEOUT - 1, 0, 1'b0, "imem_ack_at_limit");
    run_instr(I_LW, 1'b0, 0, TIMEOUT - 1, 1'b0, "dmem_ack_at_limit");
  endtask

  task automatic test_decode_fault();
    do_reset();
    start_run();
    imem_ack = 1'b1;
    instr_in = I_LW;
    set_decode(I_LW);
    mem_write = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd5 || fault !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL decode_rw_fault: state=%0d fault=%b dmem_req=%b want 5 1 0", state, fault, dmem_req);
    end
  endtask

  task automatic test_reset_in_mem();
    do_reset();
    start_run();
    run_instr(I_ADD, 1'b0, 0, 0, 1'b0, "add_pre_mem");
    imem_ack = 1'b1;
    instr_in = I_SW;
    set_decode(I_SW);
    dmem_ack = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      errors++;
      $display("FAIL mem_entry: state=%0d dmem_req=%b dmem_we=%b want 3 1 1", state, dmem_req, dmem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || retired !== '0 || ir !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_mem: state=%0d dmem_req=%b dmem_we=%b retired=%0d ir=%h want 0 0 0 0 0",
               state, dmem_req, dmem_we, retired, ir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    start_run();
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      run_instr(I_ADD, 1'b0, 0, 0, 1'b0, "fill");
    end
    checks++;
    if (retired !== {CNT_W{1'b1}}) begin
      errors++;
      $display("FAIL retired_full: retired=%0d want %0d", retired, (1 << CNT_W) - 1);
    end
    run_instr(I_SW, 1'b0, 1, 1, 1'b1, "wrap_drop_run");
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || retired !== '0) begin
      errors++;
      $display("FAIL idle_after_drop: state=%0d retired=%0d want 0 0", state, retired);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_store();
    test_branch_jump();
    test_back_to_back();
    test_timeout();
    test_ack_on_timeout();
    test_decode_fault();
    test_reset_in_mem();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16: consecutive memory wait cycles without ack before fault; legal range 2..255.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  enables instruction sequencing.
REQ-006 imem_req  output  1  instruction fetch request; imem_ack  input  1  fetch complete; instr_in  input  32  fetched word, valid with imem_ack.
REQ-007 ir  output  32  instruction register; feeds the decode block.
REQ-008 branch, jump, mem_read, mem_write, write_enable  input  1 each  decode control outputs for the current ir.
REQ-009 take_branch  input  1  branch condition from the ALU compare.
REQ-010 dmem_req  output  1  data access request; dmem_we  output  1  write strobe; dmem_ack  input  1  access complete.
REQ-011 pc_we  output  1  one-cycle PC update pulse; pc_sel  output  2  00 = PC+4, 01 = branch target, 10 = jump target, 11 unused.
REQ-012 rf_we  output  1  one-cycle register-file write pulse.
REQ-013 state  output  3  current state encoding; fault  output  1  sticky error flag; retired  output  CNT_W  instructions completed.

Function
REQ-014 States and encodings SHALL be IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4, FAULT=5; 6 and 7 SHALL fall to FAULT.
REQ-015 IDLE: run=1 -> FETCH next cycle; otherwise hold.
REQ-016 FETCH: imem_req=1 held until imem_ack; on ack ir <= instr_in and go to DECODE.
REQ-017 DECODE: lasts one cycle; mem_read&mem_write both 1 -> FAULT; either one 1 -> MEM; else -> WB.
REQ-018 MEM: dmem_req=1, dmem_we=mem_write, held until dmem_ack, then -> WB.
REQ-019 WB: pc_we=1; pc_sel=10 if jump, else 01 if branch&take_branch, else 00; rf_we=write_enable & ~mem_write (stores never write the register file); retired += 1, wrapping to 0; then -> FETCH if run=1, else IDLE.
REQ-020 Latency: non-memory instruction with zero-wait ack = 3 cycles FETCH-to-FETCH; memory instruction = 4 cycles; each wait cycle adds one.
REQ-021 Wait timer SHALL clear on entry to FETCH or MEM and count each cycle the request is unacknowledged; on the TIMEOUT-th consecutive unacknowledged cycle -> FAULT.
REQ-022 An ack arriving on the same cycle the timeout would fire SHALL win; no fault.
REQ-023 run deasserted mid-instruction SHALL NOT abort; the instruction completes through WB, then IDLE.
REQ-024 FAULT: fault=1, all request/strobe outputs 0, held until reset; run ignored.
REQ-025 imem_req, dmem_req, dmem_we, pc_we and rf_we SHALL be decoded from the state register only; no input-to-output combinational path except pc_sel and rf_we from decode inputs in WB.
REQ-026 An ack received outside the matching wait state SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, ir=0, retired=0, fault=0, wait timer=0, and all request/strobe outputs to 0, including mid-transaction.
REQ-028 After rst_n release, the first possible transition is IDLE->FETCH on the first rising edge with run=1.

Structure
REQ-029 State encodings, pc_sel codes and the RISC-V opcode constants shared with decode SHALL live in a shared package.
REQ-030 The wait timer SHALL be a sub-module wait_timer (clear, count enable, expire output, parameter TIMEOUT).

Verification
REQ-031 Bench: run=1; ADD 0x002081B3 with imem_ack on first cycle -> states 1,2,4; rf_we=1, pc_sel=00, retired=1 after 3 cycles.
REQ-032 Bench: store SW 0x0020A023, dmem_ack after 2 wait cycles -> dmem_we=1 for 3 cycles, rf_we=0 in WB, total 6 cycles.
REQ-033 Bench: BEQ with take_branch=1 -> pc_sel=01 in WB; JAL 0x0000006F -> pc_sel=10, rf_we=1.
REQ-034 Bench: imem_ack withheld, TIMEOUT=16 -> fault=1 after 16 FETCH cycles; ack exactly on cycle 16 -> no fault.
REQ-035 Bench: rst_n pulsed low during MEM with dmem_req=1 -> dmem_req=0 and state=0 without a clock edge; retired=0.
REQ-036 Bench: retired preset to all-ones via 2^CNT_W-1 instructions (CNT_W=4 build) -> wraps to 0 on next WB; run dropped in DECODE -> WB completes, then IDLE.
